// File: rtl/oled_spi_rx.sv
// oled_spi_rx
// SPI-slave receiver for the OLED command/data stream. It deserialises bytes
// (MSB first, sampled on rising sclk), decodes the page, column and display
// commands, and writes data bytes into a page/column frame buffer that has a
// registered readback port.
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active low
//   cs         SPI chip select, active low
//   sclk       SPI clock, idle high
//   sdo        serial data from the controller, MSB first
//   dc         0 = command byte, 1 = data byte, sampled with bit 0
//   rd_addr    readback address {page, col}
//   rd_data    frame buffer byte at rd_addr, one clk later
//   byte_valid one-cycle pulse per received byte
//   byte_out   last received byte
//   byte_dc    dc value of the last received byte
//   cur_page   current write page
//   cur_col    current write column
//   disp_on    display-on flag
//   frame_done one-cycle pulse on the write to the last address
//   err_frame  one-cycle pulse when cs rises in the middle of a byte
module oled_spi_rx #(
    parameter  int PAGES       = 4,
    parameter  int COLS        = 128,
    parameter  int SYNC_STAGES = 2,
    localparam int PW          = $clog2(PAGES),
    localparam int CW          = $clog2(COLS),
    localparam int AW          = PW + CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cs,
    input  logic          sclk,
    input  logic          sdo,
    input  logic          dc,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          byte_valid,
    output logic [7:0]    byte_out,
    output logic          byte_dc,
    output logic [PW-1:0] cur_page,
    output logic [CW-1:0] cur_col,
    output logic          disp_on,
    output logic          frame_done,
    output logic          err_frame
);

    typedef enum logic {P_IDLE, P_PAGE} pstate_e;

    // Each stage holds {cs, sclk, sdo, dc}.
    logic [3:0]    sync_q [SYNC_STAGES];
    logic          cs_s, sclk_s, sdo_s, dc_s;

    logic          sclk_prev_q;
    logic          cs_prev_q;
    logic          armed_q;
    logic [6:0]    shreg_q;
    logic [2:0]    bit_cnt_q;
    pstate_e       pstate_q;
    logic [PW-1:0] cur_page_q;
    logic [CW-1:0] cur_col_q;
    logic          disp_on_q;
    logic          byte_valid_q;
    logic [7:0]    byte_out_q;
    logic          byte_dc_q;
    logic          frame_done_q;
    logic          err_frame_q;
    logic [7:0]    rd_data_q;
    logic [7:0]    mem [PAGES*COLS];

    logic          sclk_rise;
    logic          shift_en;
    logic          byte_done;
    logic [7:0]    byte_d;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] wr_addr_d;
    logic          wr_en;

    // Replace the low nibble of the column.
    function automatic logic [CW-1:0] col_lo(input logic [CW-1:0] c, input logic [3:0] n);
        logic [CW-1:0] r;
        r = c;
        for (int i = 0; i < 4 && i < CW; i++) r[i] = n[i];
        return r;
    endfunction

    // Replace column bits [7:4]; bits beyond the column width are dropped.
    function automatic logic [CW-1:0] col_hi(input logic [CW-1:0] c, input logic [3:0] n);
        logic [CW-1:0] r;
        r = c;
        for (int i = 4; i < 8 && i < CW; i++) r[i] = n[i-4];
        return r;
    endfunction

    // Low page bits of a byte field of width nb (i.e. value mod PAGES).
    function automatic logic [PW-1:0] page_of(input logic [7:0] b, input int nb);
        logic [PW-1:0] r;
        r = '0;
        for (int i = 0; i < PW && i < 8; i++) if (i < nb) r[i] = b[i];
        return r;
    endfunction

    assign cs_s   = sync_q[SYNC_STAGES-1][3];
    assign sclk_s = sync_q[SYNC_STAGES-1][2];
    assign sdo_s  = sync_q[SYNC_STAGES-1][1];
    assign dc_s   = sync_q[SYNC_STAGES-1][0];

    // Reception is only enabled once cs has been seen high after reset, so a
    // reset in the middle of a byte never resumes on a misaligned bit.
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign shift_en  = armed_q & ~cs_s & sclk_rise;
    assign byte_d    = {shreg_q, sdo_s};
    assign byte_done = shift_en & (bit_cnt_q == 3'd7);

    assign wr_addr   = {cur_page_q, cur_col_q};
    assign wr_addr_d = wr_addr + AW'(1);
    assign wr_en     = byte_done & dc_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            sclk_prev_q  <= 1'b0;
            cs_prev_q    <= 1'b0;
            armed_q      <= 1'b0;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            pstate_q     <= P_IDLE;
            cur_page_q   <= '0;
            cur_col_q    <= '0;
            disp_on_q    <= 1'b0;
            byte_valid_q <= 1'b0;
            byte_out_q   <= '0;
            byte_dc_q    <= 1'b0;
            frame_done_q <= 1'b0;
            err_frame_q  <= 1'b0;
        end else begin
            sync_q[0] <= {cs, sclk, sdo, dc};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            sclk_prev_q  <= sclk_s;
            cs_prev_q    <= cs_s;
            byte_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            err_frame_q  <= cs_s & ~cs_prev_q & (bit_cnt_q != 3'd0);

            if (cs_s) begin
                armed_q   <= 1'b1;
                bit_cnt_q <= '0;
            end else if (shift_en) begin
                shreg_q   <= byte_d[6:0];
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end

            if (byte_done) begin
                byte_valid_q <= 1'b1;
                byte_out_q   <= byte_d;
                byte_dc_q    <= dc_s;
                if (dc_s) begin
                    // Linear {page, col} increment gives the column wrap and
                    // page carry; all-ones is the last address of the frame.
                    pstate_q     <= P_IDLE;
                    {cur_page_q, cur_col_q} <= wr_addr_d;
                    frame_done_q <= &wr_addr;
                end else begin
                    case (pstate_q)
                        P_PAGE: begin
                            cur_page_q <= page_of(byte_d, 8);
                            pstate_q   <= P_IDLE;
                        end
                        default: begin
                            if (byte_d == 8'h22)             pstate_q   <= P_PAGE;
                            else if (byte_d[7:4] == 4'h0)    cur_col_q  <= col_lo(cur_col_q, byte_d[3:0]);
                            else if (byte_d[7:4] == 4'h1)    cur_col_q  <= col_hi(cur_col_q, byte_d[3:0]);
                            else if (byte_d[7:3] == 5'h16)   cur_page_q <= page_of(byte_d, 3);
                            else if (byte_d == 8'hAE)        disp_on_q  <= 1'b0;
                            else if (byte_d == 8'hAF)        disp_on_q  <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    // Frame buffer contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= byte_d;
    end

    // Read-before-write: a same-cycle write to rd_addr returns the old byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rd_data_q <= '0;
        else      rd_data_q <= mem[rd_addr];
    end

    assign rd_data    = rd_data_q;
    assign byte_valid = byte_valid_q;
    assign byte_out   = byte_out_q;
    assign byte_dc    = byte_dc_q;
    assign cur_page   = cur_page_q;
    assign cur_col    = cur_col_q;
    assign disp_on    = disp_on_q;
    assign frame_done = frame_done_q;
    assign err_frame  = err_frame_q;

endmodule

// File: tb/tb_oled_spi_rx.sv
// Directed bench for oled_spi_rx: SPI bytes are driven bit by bit, every byte
// that should be received is pushed to an expected queue, and a monitor
// collects byte_valid events for in-order comparison.
module tb_oled_spi_rx;

    localparam int PAGES = 4;
    localparam int COLS  = 128;
    localparam int AW    = 9;

    logic          clk = 1'b0;
    logic          rst, cs, sclk, sdo, dc;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          byte_valid;
    logic [7:0]    byte_out;
    logic          byte_dc;
    logic [1:0]    cur_page;
    logic [6:0]    cur_col;
    logic          disp_on;
    logic          frame_done;
    logic          err_frame;

    int            total = 0;
    int            bad   = 0;
    logic [8:0]    exp_q [$];
    logic [8:0]    rx_q  [$];
    int            ex_idx = 0;
    int            rx_idx = 0;
    int            fd_cnt = 0;
    int            err_cnt = 0;
    logic [7:0]    fd_byte = 8'h00;
    logic [7:0]    exp_mem [PAGES*COLS];
    int            fd0, e0;

    always #5 clk = ~clk;

    oled_spi_rx #(.PAGES(PAGES), .COLS(COLS), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .cs         (cs),
        .sclk       (sclk),
        .sdo        (sdo),
        .dc         (dc),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .byte_valid (byte_valid),
        .byte_out   (byte_out),
        .byte_dc    (byte_dc),
        .cur_page   (cur_page),
        .cur_col    (cur_col),
        .disp_on    (disp_on),
        .frame_done (frame_done),
        .err_frame  (err_frame)
    );

    // Monitor: only this process writes rx_q and the pulse counters.
    always @(negedge clk) begin
        if (byte_valid) rx_q.push_back({byte_dc, byte_out});
        if (frame_done) begin
            fd_cnt++;
            fd_byte = byte_out;
        end
        if (err_frame) err_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_lo();
        cs = 1'b0;
        clks(4);
    endtask

    task automatic cs_hi();
        cs = 1'b1;
        clks(4);
    endtask

    // Drive the top nbits of b, MSB first; each sclk phase lasts ph clocks.
    task automatic spi_bits(input logic [7:0] b, input logic d, input int nbits, input int ph);
        dc = d;
        for (int i = 7; i > 7 - nbits; i--) begin
            sclk = 1'b0;
            sdo  = b[i];
            clks(ph);
            sclk = 1'b1;
            clks(ph);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic d, input int ph);
        spi_bits(b, d, 8, ph);
        exp_q.push_back({d, b});
    endtask

    task automatic sb_check(input string tag);
        clks(12);
        chk({tag, "_count"}, rx_q.size() - rx_idx, exp_q.size() - ex_idx);
        while (rx_idx < rx_q.size() && ex_idx < exp_q.size()) begin
            chk(tag, rx_q[rx_idx], exp_q[ex_idx]);
            rx_idx++;
            ex_idx++;
        end
        rx_idx = rx_q.size();
        ex_idx = exp_q.size();
    endtask

    task automatic rd_check(input int a);
        rd_addr = AW'(a);
        @(posedge clk);
        #1;
        chk("rd_data", rd_data, exp_mem[a]);
        @(negedge clk);
    endtask

    task automatic reset_outputs_check(input string tag);
        chk({tag, "_byte_valid"}, byte_valid, 0);
        chk({tag, "_byte_out"},   byte_out,   0);
        chk({tag, "_byte_dc"},    byte_dc,    0);
        chk({tag, "_cur_page"},   cur_page,   0);
        chk({tag, "_cur_col"},    cur_col,    0);
        chk({tag, "_disp_on"},    disp_on,    0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_err_frame"},  err_frame,  0);
        chk({tag, "_rd_data"},    rd_data,    0);
    endtask

    initial begin
        rst = 1'b0; cs = 1'b1; sclk = 1'b1; sdo = 1'b0; dc = 1'b0; rd_addr = '0;
        for (int a = 0; a < PAGES*COLS; a++) exp_mem[a] = 8'h00;
        clks(3);
        reset_outputs_check("rst0");
        rst = 1'b1;
        clks(6);

        // Command sequence: page 2 via 0x22 parameter, column 0, one data byte.
        cs_lo();
        send(8'h22, 1'b0, 3);
        send(8'h02, 1'b0, 3);
        send(8'h00, 1'b0, 3);
        send(8'h10, 1'b0, 3);
        send(8'h5A, 1'b1, 3);
        exp_mem[2*COLS + 0] = 8'h5A;
        cs_hi();
        sb_check("cmd");
        chk("cmd_page", cur_page, 2);
        chk("cmd_col",  cur_col,  1);
        rd_check(2*COLS + 0);

        // Full frame.
        fd0 = fd_cnt;
        cs_lo();
        for (int p = 0; p < PAGES; p++) begin
            send(8'h22, 1'b0, 3);
            send(8'(p), 1'b0, 3);
            send(8'h00, 1'b0, 3);
            send(8'h10, 1'b0, 3);
            for (int c = 0; c < COLS; c++) begin
                send(8'((p*COLS + c) & 255), 1'b1, 3);
                exp_mem[p*COLS + c] = 8'((p*COLS + c) & 255);
            end
        end
        cs_hi();
        sb_check("frame");
        chk("frame_done_cnt", fd_cnt - fd0, 1);
        chk("frame_done_byte", fd_byte, 8'hFF);
        chk("frame_wrap_page", cur_page, 0);
        chk("frame_wrap_col",  cur_col,  0);
        for (int a = 0; a < PAGES*COLS; a++) rd_check(a);

        // Column wrap from page 1, column 126 into page 2.
        fd0 = fd_cnt;
        cs_lo();
        send(8'h22, 1'b0, 3);
        send(8'h01, 1'b0, 3);
        send(8'h0E, 1'b0, 3);
        send(8'h17, 1'b0, 3);
        send(8'hA1, 1'b1, 3);
        send(8'hA2, 1'b1, 3);
        send(8'hA3, 1'b1, 3);
        exp_mem[1*COLS + 126] = 8'hA1;
        exp_mem[1*COLS + 127] = 8'hA2;
        exp_mem[2*COLS + 0]   = 8'hA3;
        cs_hi();
        sb_check("wrap");
        chk("wrap_page", cur_page, 2);
        chk("wrap_col",  cur_col,  1);
        chk("wrap_no_frame_done", fd_cnt - fd0, 0);
        rd_check(1*COLS + 126);
        rd_check(1*COLS + 127);
        rd_check(2*COLS + 0);

        // Parser corners: 0x22 as a page parameter, data aborting P_PAGE,
        // low column nibble, display off, ignored command, 0xB5 -> page 1.
        cs_lo();
        send(8'h22, 1'b0, 3);
        send(8'h22, 1'b0, 3);
        send(8'h22, 1'b0, 3);
        send(8'h77, 1'b1, 3);
        exp_mem[2*COLS + 1] = 8'h77;
        send(8'h05, 1'b0, 3);
        send(8'hAE, 1'b0, 3);
        send(8'h3C, 1'b0, 3);
        send(8'hB5, 1'b0, 3);
        cs_hi();
        sb_check("parse");
        chk("parse_page",    cur_page, 1);
        chk("parse_col",     cur_col,  5);
        chk("parse_disp_on", disp_on,  0);
        rd_check(2*COLS + 1);

        // Framing error: five edges then cs high.
        e0 = err_cnt;
        cs_lo();
        spi_bits(8'h55, 1'b0, 5, 3);
        cs_hi();
        clks(4);
        chk("err_frame_cnt", err_cnt - e0, 1);
        sb_check("err_nobyte");
        cs_lo();
        send(8'hAF, 1'b0, 3);
        cs_hi();
        sb_check("after_err");
        chk("disp_on_after_err", disp_on, 1);

        // Fast and slow sclk with cs held low across both bytes.
        e0 = err_cnt;
        cs_lo();
        send(8'hC3, 1'b0, 3);
        send(8'hC3, 1'b0, 40);
        cs_hi();
        sb_check("speed");
        chk("speed_byte_out", byte_out, 8'hC3);
        chk("speed_no_err", err_cnt - e0, 0);

        // Reset in the middle of a byte with cs held low.
        e0 = err_cnt;
        cs_lo();
        spi_bits(8'hF0, 1'b1, 3, 3);
        rst = 1'b0;
        clks(3);
        reset_outputs_check("rst_mid");
        rst = 1'b1;
        clks(6);
        spi_bits(8'h5A, 1'b1, 8, 3);
        sb_check("rst_no_rx");
        cs_hi();
        cs_lo();
        send(8'h81, 1'b0, 3);
        cs_hi();
        sb_check("rst_rx");
        chk("rst_no_err", err_cnt - e0, 0);
        chk("rst_page", cur_page, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
